// File: rtl/vend_pkg.sv
// Shared types and coin table for the vending-machine controller.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vend_state_e;

    typedef logic [1:0] coin_idx_t;

    localparam int COIN_VAL_W = 5;
    localparam logic [COIN_VAL_W-1:0] COIN_VAL_1  = 5'd1;
    localparam logic [COIN_VAL_W-1:0] COIN_VAL_5  = 5'd5;
    localparam logic [COIN_VAL_W-1:0] COIN_VAL_10 = 5'd10;
    localparam logic [COIN_VAL_W-1:0] COIN_VAL_20 = 5'd20;

    function automatic logic [COIN_VAL_W-1:0] coin_value(input coin_idx_t idx);
        logic [COIN_VAL_W-1:0] val;
        case (idx)
            2'd0:    val = COIN_VAL_1;
            2'd1:    val = COIN_VAL_5;
            2'd2:    val = COIN_VAL_10;
            2'd3:    val = COIN_VAL_20;
            default: val = COIN_VAL_1;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Greedy change selector: picks the largest coin whose value does not exceed credit.
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 7
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          chg_coin
);

    logic [CREDIT_W+COIN_VAL_W-1:0] credit_ext_s;

    assign credit_ext_s = {{COIN_VAL_W{1'b0}}, credit};

    // Widened compare keeps the coin table valid for any credit width.
    always_comb begin
        chg_coin = 2'd0;
        if (credit_ext_s >= {{CREDIT_W{1'b0}}, COIN_VAL_20}) begin
            chg_coin = 2'd3;
        end else if (credit_ext_s >= {{CREDIT_W{1'b0}}, COIN_VAL_10}) begin
            chg_coin = 2'd2;
        end else if (credit_ext_s >= {{CREDIT_W{1'b0}}, COIN_VAL_5}) begin
            chg_coin = 2'd1;
        end else begin
            chg_coin = 2'd0;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: credit, item browsing, vend and change handshakes.
// Optional per-item stock tracking is enabled by defining VEND_STOCK_EN.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int                            N_ITEMS    = 5,
    parameter int                            CREDIT_W   = 7,
    parameter int                            MAX_CREDIT = 99,
    parameter logic [N_ITEMS*CREDIT_W-1:0]   PRICES     = {7'd8, 7'd10, 7'd6, 7'd5, 7'd7},
    parameter int                            STOCK_W    = 4,
    localparam int                           SEL_W      = $clog2(N_ITEMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin_valid,
    input  logic [1:0]           coin_sel,
    output logic                 coin_reject,
    input  logic                 l_btn,
    input  logic                 r_btn,
    input  logic                 c_btn,
    input  logic                 refund_btn,
    output logic [SEL_W-1:0]     sel,
    output logic [CREDIT_W-1:0]  sel_price,
    output logic [CREDIT_W-1:0]  credit,
    output logic [N_ITEMS-1:0]   afford,
    output logic                 deny,
    output logic                 vend_valid,
    input  logic                 vend_ready,
    output logic [SEL_W-1:0]     vend_item,
    output logic                 chg_valid,
    input  logic                 chg_ready,
    output logic [1:0]           chg_coin,
    input  logic                 restock_valid,
    input  logic [SEL_W-1:0]     restock_item,
    input  logic [STOCK_W-1:0]   restock_qty,
    output logic [N_ITEMS-1:0]   sold_out
);

    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N_ITEMS - 1);
    localparam logic [CREDIT_W:0] MAX_SUM  = (CREDIT_W + 1)'(MAX_CREDIT);

    vend_state_e          state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [SEL_W-1:0]     vend_item_q, vend_item_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 deny_q, deny_d;

    logic [CREDIT_W-1:0]  price_s [N_ITEMS];
    logic [N_ITEMS-1:0]   in_stock_s;
    logic [N_ITEMS-1:0]   afford_s;
    logic [CREDIT_W:0]    coin_sum_s;
    logic [1:0]           chg_coin_s;
    logic [CREDIT_W-1:0]  chg_val_s;
    logic [CREDIT_W-1:0]  vend_price_s;
    logic                 vend_hs_s;

    vend_change_gen #(
        .CREDIT_W (CREDIT_W)
    ) u_change_gen (
        .credit   (credit_q),
        .chg_coin (chg_coin_s)
    );

    assign coin_sum_s   = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(coin_sel));
    assign chg_val_s    = CREDIT_W'(coin_value(chg_coin_s));
    assign vend_price_s = price_s[vend_item_q];
    assign vend_hs_s    = (state_q == ST_VEND) && vend_ready;

    // Unpack the price table and derive per-item affordability.
    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            price_s[i]  = PRICES[i*CREDIT_W +: CREDIT_W];
            afford_s[i] = (credit_q >= price_s[i]) && in_stock_s[i];
        end
    end

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock_q [N_ITEMS];
    logic [STOCK_W-1:0] stock_d [N_ITEMS];

    // Restock overrides the vend decrement on the same item and cycle.
    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (restock_valid && (restock_item == SEL_W'(i))) begin
                stock_d[i] = restock_qty;
            end else if (vend_hs_s && (vend_item_q == SEL_W'(i))) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end else begin
                stock_d[i] = stock_q[i];
            end
            in_stock_s[i] = (stock_q[i] != '0);
        end
    end

    // Stock counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign sold_out = ~in_stock_s;
`else
    logic unused_restock_s;

    assign unused_restock_s = ^{restock_valid, restock_item, restock_qty};
    assign in_stock_s       = '1;
    assign sold_out         = '0;
`endif

    // Next-state logic; in IDLE/SELECT refund beats confirm beats coin.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        sel_d         = sel_q;
        vend_item_d   = vend_item_q;
        coin_reject_d = 1'b0;
        deny_d        = 1'b0;
        case (state_q)
            ST_IDLE, ST_SELECT: begin
                if (refund_btn && (state_q == ST_SELECT)) begin
                    state_d       = ST_CHANGE;
                    coin_reject_d = coin_valid;
                end else if (c_btn && afford_s[sel_q]) begin
                    state_d       = ST_VEND;
                    vend_item_d   = sel_q;
                    coin_reject_d = coin_valid;
                end else begin
                    deny_d = c_btn;
                    if (coin_valid && (coin_sum_s <= MAX_SUM)) begin
                        credit_d = coin_sum_s[CREDIT_W-1:0];
                    end else begin
                        credit_d      = credit_q;
                        coin_reject_d = coin_valid;
                    end
                    if (l_btn && !r_btn) begin
                        sel_d = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);
                    end else if (r_btn && !l_btn) begin
                        sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
                    end else begin
                        sel_d = sel_q;
                    end
                    state_d = (credit_d != '0) ? ST_SELECT : ST_IDLE;
                end
            end
            ST_VEND: begin
                coin_reject_d = coin_valid;
                if (vend_ready) begin
                    credit_d = credit_q - vend_price_s;
                    state_d  = (credit_q == vend_price_s) ? ST_IDLE : ST_SELECT;
                end else begin
                    state_d = ST_VEND;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                if (chg_ready) begin
                    credit_d = credit_q - chg_val_s;
                    state_d  = (credit_q == chg_val_s) ? ST_IDLE : ST_CHANGE;
                end else begin
                    state_d = ST_CHANGE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            sel_q         <= '0;
            vend_item_q   <= '0;
            coin_reject_q <= 1'b0;
            deny_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            sel_q         <= sel_d;
            vend_item_q   <= vend_item_d;
            coin_reject_q <= coin_reject_d;
            deny_q        <= deny_d;
        end
    end

    assign coin_reject = coin_reject_q;
    assign deny        = deny_q;
    assign credit      = credit_q;
    assign sel         = sel_q;
    assign sel_price   = price_s[sel_q];
    assign afford      = afford_s;
    assign vend_valid  = (state_q == ST_VEND);
    assign vend_item   = vend_item_q;
    assign chg_valid   = (state_q == ST_CHANGE);
    assign chg_coin    = chg_coin_s;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl; stock checks apply when VEND_STOCK_EN is defined.
module tb_vend_ctrl;
    import vend_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_sel = 2'd0;
    logic       coin_reject;
    logic       l_btn = 1'b0, r_btn = 1'b0, c_btn = 1'b0, refund_btn = 1'b0;
    logic [2:0] sel;
    logic [6:0] sel_price;
    logic [6:0] credit;
    logic [4:0] afford;
    logic       deny;
    logic       vend_valid;
    logic       vend_ready = 1'b0;
    logic [2:0] vend_item;
    logic       chg_valid;
    logic       chg_ready = 1'b0;
    logic [1:0] chg_coin;
    logic       restock_valid = 1'b0;
    logic [2:0] restock_item = 3'd0;
    logic [3:0] restock_qty = 4'd0;
    logic [4:0] sold_out;

    int n_cmp = 0;
    int n_err = 0;

    vend_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .coin_valid    (coin_valid),
        .coin_sel      (coin_sel),
        .coin_reject   (coin_reject),
        .l_btn         (l_btn),
        .r_btn         (r_btn),
        .c_btn         (c_btn),
        .refund_btn    (refund_btn),
        .sel           (sel),
        .sel_price     (sel_price),
        .credit        (credit),
        .afford        (afford),
        .deny          (deny),
        .vend_valid    (vend_valid),
        .vend_ready    (vend_ready),
        .vend_item     (vend_item),
        .chg_valid     (chg_valid),
        .chg_ready     (chg_ready),
        .chg_coin      (chg_coin),
        .restock_valid (restock_valid),
        .restock_item  (restock_item),
        .restock_qty   (restock_qty),
        .sold_out      (sold_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] c);
        coin_sel   = c;
        coin_valid = 1'b1;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic press(input logic l, input logic r, input logic c, input logic f);
        l_btn = l; r_btn = r; c_btn = c; refund_btn = f;
        tick();
        l_btn = 1'b0; r_btn = 1'b0; c_btn = 1'b0; refund_btn = 1'b0;
    endtask

    task automatic drain();
        chg_ready = 1'b1;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 12 && chg_valid; k++) tick();
        chg_ready = 1'b0;
        check_eq("drain_chg_valid", {31'd0, chg_valid}, 32'd0);
        check_eq("drain_credit", {25'd0, credit}, 32'd0);
    endtask

    logic [1:0] chg_exp [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_credit", {25'd0, credit}, 32'd0);
        check_eq("rst_sel", {29'd0, sel}, 32'd0);
        check_eq("rst_vend_valid", {31'd0, vend_valid}, 32'd0);
        check_eq("rst_chg_valid", {31'd0, chg_valid}, 32'd0);
        check_eq("rst_reject", {31'd0, coin_reject}, 32'd0);
        check_eq("rst_deny", {31'd0, deny}, 32'd0);
        check_eq("rst_afford", {27'd0, afford}, 32'd0);
        check_eq("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
`ifdef VEND_STOCK_EN
        check_eq("rst_sold_out", {27'd0, sold_out}, 32'h1f);
`else
        check_eq("rst_sold_out", {27'd0, sold_out}, 32'd0);
`endif
        rst = 1'b1;
        tick();

`ifdef VEND_STOCK_EN
        for (int i = 0; i < 5; i++) begin
            restock_valid = 1'b1; restock_item = 3'(i); restock_qty = 4'd15;
            tick();
        end
        restock_valid = 1'b0;
        check_eq("restock_all", {27'd0, sold_out}, 32'd0);
`endif

        // 10 + 5 = 15 covers every price.
        coin(2'd2);
        check_eq("coin10_credit", {25'd0, credit}, 32'd10);
        coin(2'd1);
        check_eq("coin15_credit", {25'd0, credit}, 32'd15);
        check_eq("coin15_afford", {27'd0, afford}, 32'h1f);
        check_eq("coin15_state", 32'(dut.state_q), 32'(ST_SELECT));

        repeat (3) press(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("r3_sel", {29'd0, sel}, 32'd3);
        check_eq("r3_price", {25'd0, sel_price}, 32'd10);

        vend_ready = 1'b0;
        press(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check_eq("vend_wait_valid", {31'd0, vend_valid}, 32'd1);
            check_eq("vend_wait_item", {29'd0, vend_item}, 32'd3);
            check_eq("vend_wait_credit", {25'd0, credit}, 32'd15);
            tick();
        end
        vend_ready = 1'b1;
        check_eq("vend_hs_valid", {31'd0, vend_valid}, 32'd1);
        check_eq("vend_hs_credit", {25'd0, credit}, 32'd15);
        tick();
        vend_ready = 1'b0;
        check_eq("vend_done_valid", {31'd0, vend_valid}, 32'd0);
        check_eq("vend_done_credit", {25'd0, credit}, 32'd5);
        check_eq("vend_done_state", 32'(dut.state_q), 32'(ST_SELECT));

        // 5 + 20 + 10 + 1 + 1 = 37 -> change 20,10,5,1,1.
        coin(2'd3); coin(2'd2); coin(2'd0); coin(2'd0);
        check_eq("c37_credit", {25'd0, credit}, 32'd37);
        chg_ready = 1'b1;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check_eq("chg_valid", {31'd0, chg_valid}, 32'd1);
            check_eq("chg_coin", {30'd0, chg_coin}, {30'd0, chg_exp[k]});
            tick();
        end
        chg_ready = 1'b0;
        check_eq("chg_end_valid", {31'd0, chg_valid}, 32'd0);
        check_eq("chg_end_credit", {25'd0, credit}, 32'd0);
        check_eq("chg_end_state", 32'(dut.state_q), 32'(ST_IDLE));

        repeat (4) coin(2'd3);
        coin(2'd2); coin(2'd1);
        check_eq("c95_credit", {25'd0, credit}, 32'd95);
        coin(2'd2);
        check_eq("ovf_reject", {31'd0, coin_reject}, 32'd1);
        check_eq("ovf_credit", {25'd0, credit}, 32'd95);
        tick();
        check_eq("ovf_reject_drop", {31'd0, coin_reject}, 32'd0);
        drain();

        repeat (4) coin(2'd0);
        repeat (2) press(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("l2_sel", {29'd0, sel}, 32'd1);
        check_eq("l2_price", {25'd0, sel_price}, 32'd5);
        check_eq("c4_afford", {27'd0, afford}, 32'd0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("deny_pulse", {31'd0, deny}, 32'd1);
        check_eq("deny_no_vend", {31'd0, vend_valid}, 32'd0);
        tick();
        check_eq("deny_drop", {31'd0, deny}, 32'd0);
        check_eq("deny_credit", {25'd0, credit}, 32'd4);

        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("wrap_sel", {29'd0, sel}, 32'd4);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("both_sel", {29'd0, sel}, 32'd4);

        // Credit 9 at item 4 (price 8); coin arrives with the confirm.
        coin(2'd1);
        vend_ready = 1'b0;
        coin_sel = 2'd0; coin_valid = 1'b1; c_btn = 1'b1;
        tick();
        coin_valid = 1'b0; c_btn = 1'b0;
        check_eq("cc_vend_valid", {31'd0, vend_valid}, 32'd1);
        check_eq("cc_reject", {31'd0, coin_reject}, 32'd1);
        check_eq("cc_credit", {25'd0, credit}, 32'd9);
        check_eq("cc_item", {29'd0, vend_item}, 32'd4);
        vend_ready = 1'b1;
        tick();
        vend_ready = 1'b0;
        check_eq("cc_done_credit", {25'd0, credit}, 32'd1);
        check_eq("cc_done_state", 32'(dut.state_q), 32'(ST_SELECT));
        drain();

`ifdef VEND_STOCK_EN
        restock_valid = 1'b1; restock_item = 3'd1; restock_qty = 4'd1;
        tick();
        restock_valid = 1'b0;
        check_eq("stk_restock", {31'd0, sold_out[1]}, 32'd0);
        coin(2'd2);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("stk_sel", {29'd0, sel}, 32'd1);
        vend_ready = 1'b1;
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("stk_vend_valid", {31'd0, vend_valid}, 32'd1);
        tick();
        vend_ready = 1'b0;
        check_eq("stk_credit", {25'd0, credit}, 32'd5);
        check_eq("stk_sold_out", {31'd0, sold_out[1]}, 32'd1);
        check_eq("stk_afford", {31'd0, afford[1]}, 32'd0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("stk_deny", {31'd0, deny}, 32'd1);
        check_eq("stk_no_vend", {31'd0, vend_valid}, 32'd0);
        drain();
`else
        restock_valid = 1'b1; restock_item = 3'd1; restock_qty = 4'd0;
        tick();
        restock_valid = 1'b0;
        check_eq("nostk_sold_out", {27'd0, sold_out}, 32'd0);
`endif

        coin(2'd2);
        chg_ready = 1'b0;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("mid_chg_valid", {31'd0, chg_valid}, 32'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_chg_valid", {31'd0, chg_valid}, 32'd0);
        check_eq("mid_rst_credit", {25'd0, credit}, 32'd0);
        rst = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised vending-machine controller: tracks coin credit, lets the user browse N_ITEMS products with left/right buttons, vends the selected item over a valid/ready handshake and refunds remaining credit as a greedy coin stream. It sits between the debounced button/coin front-end and the seven-segment and LED display logic, and generalises the fixed five-item controller to any item count and price table, with real change return and optional stock tracking.

## Interface
- N_ITEMS, 5, number of products (2..16)
- CREDIT_W, 7, credit and price width
- MAX_CREDIT, 99, credit ceiling; coins that would exceed it are rejected
- PRICES, {8,10,6,5,7}, packed N_ITEMS*CREDIT_W; item i at [i*CREDIT_W +: CREDIT_W], so item0=7, 1=5, 2=6, 3=10, 4=8
- STOCK_W, 4, per-item stock counter width (only with VEND_STOCK_EN)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- coin_valid  in  1  single-cycle coin-inserted pulse
- coin_sel  in  2  coin index: 0=1, 1=5, 2=10, 3=20
- coin_reject  out  1  one-cycle pulse: coin returned, not credited
- l_btn, r_btn, c_btn, refund_btn  in  1 each  single-cycle debounced pulses
- sel  out  $clog2(N_ITEMS)  current selection
- sel_price  out  CREDIT_W  price of sel
- credit  out  CREDIT_W  current credit
- afford  out  N_ITEMS  bit i = credit >= price i (and item i in stock)
- deny  out  1  one-cycle pulse: confirm refused
- vend_valid / vend_ready  out / in  1  vend handshake; vend_item out $clog2(N_ITEMS), stable while vend_valid
- chg_valid / chg_ready  out / in  1  change handshake; chg_coin out 2, coin index, stable while chg_valid
- restock_valid  in  1, restock_item  in  $clog2(N_ITEMS), restock_qty  in  STOCK_W
- sold_out  out  N_ITEMS  bit i = stock i is 0

## Operation
- States: IDLE (credit 0), SELECT (credit > 0), VEND, CHANGE.
- Reset: state IDLE, credit 0, sel 0, all pulse/valid outputs 0, stock counters 0.
- Per-cycle priority in IDLE/SELECT: refund_btn > c_btn > coin_valid.
- Coin: credit + value computed in CREDIT_W+1 bits. If the sum is <= MAX_CREDIT, credit is updated. Otherwise coin_reject is pulsed. Coins are also rejected in VEND/CHANGE and in any cycle where refund or confirm is accepted.
- Selection: l_btn decrements sel and r_btn increments it, wrapping 0 <-> N_ITEMS-1. Both buttons in the same cycle leave sel unchanged. Selection is frozen in VEND and CHANGE.
- c_btn: if afford[sel], go to VEND with vend_item=sel. Otherwise pulse deny and stay.
- VEND: hold vend_valid until vend_ready. On the handshake edge, credit -= price and stock[item] -= 1, then go to SELECT, or IDLE if credit becomes 0.
- refund_btn in SELECT: go to CHANGE. In IDLE it is ignored.
- CHANGE: chg_coin is the largest coin <= credit. On each chg_valid & chg_ready edge, credit -= that coin's value. At credit 0, go to IDLE.
- Mid-operation reset: all handshakes drop immediately and credit is lost.

## Timing
- Coin credit, sel change, and coin_reject/deny are visible 1 cycle after the input pulse.
- afford, sel_price, sold_out: combinational from registers, so valid in the same cycle as credit/sel.
- vend_valid rises 1 cycle after an accepted c_btn and falls the cycle after the handshake.
- chg_valid rises 1 cycle after refund. Back-to-back coins go out at one per cycle with chg_ready held high. chg_valid is low in the cycle credit reads 0.

## Configuration
- VEND_STOCK_EN defined:
  - Per-item stock counters; restock_valid loads restock_qty into restock_item (last write wins).
  - A restock of the vended item on the vend-handshake cycle takes priority over the decrement.
  - Sold-out items clear their afford bit, and confirming one pulses deny.
- VEND_STOCK_EN undefined: no counters, restock inputs ignored, sold_out tied 0, stock never limits afford.

## Structure
- Package vend_pkg: state enum, coin-index type, coin value constants {1,5,10,20}, and a coin_value() function.
- Sub-module vend_change_gen: combinational greedy chg_coin selection from credit (largest coin <= credit), instantiated once.

## Test plan
- Reset, then coin_sel 2 followed by coin_sel 1: credit 15, afford = 5'b11111, state SELECT.
- From sel 0: r_btn x3 gives sel 3 (price 10). c_btn with vend_ready low for 3 cycles: vend_valid high 4 cycles, vend_item 3, credit stays 15 until the handshake, then 5.
- Credit 37, refund_btn, chg_ready always 1: chg_coin sequence 3,2,1,0,0 over 5 cycles, then credit 0 and IDLE.
- Credit 95, coin_sel 2: coin_reject pulse, credit stays 95. Credit 4 and c_btn at sel 1 (price 5): deny, no vend_valid.
- sel 0 with l_btn gives sel 4. l_btn and r_btn together: sel unchanged. Coin and c_btn in the same cycle: vend proceeds and coin_reject pulses.
- VEND_STOCK_EN: restock item 1 qty 1. Credit 10, vend item 1 succeeds; sold_out[1] = 1, afford[1] = 0. Second confirm on item 1 gives deny.
